serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor. It computes `diff = a - b` one bit per clock, LSB first, using a half-subtractor/full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's adder cells. It sits between a ready/valid operand source and a ready/valid result sink, and trades latency for a single-bit datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operands `a`/`b` are valid this cycle.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `busy` output 1: high while in SHIFT.
- `out_valid` output 1: `diff`/`borrow_out` hold a completed result.
- `out_ready` input 1: sink accepts the result.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out` output 1: final borrow. 1 exactly when `a < b` (unsigned).

## Operation
- State machine IDLE → SHIFT → DONE → IDLE.
- Internal registers:
  - `a_sh` and `b_sh`: WIDTH each.
  - `d_sh`: WIDTH, result shift register.
  - `br`: 1 bit, running borrow.
  - `cnt`: `$clog2(WIDTH)` bits.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid && in_ready`: load `a_sh=a`, `b_sh=b`, clear `br=0` and `cnt=0`, go to SHIFT.
- **SHIFT**, one bit per cycle:
  - `x=a_sh[0]`, `y=b_sh[0]`.
  - `d = x ^ y ^ br`.
  - `br_next = (~x & y) | (~(x ^ y) & br)`.
  - `a_sh` and `b_sh` shift right by 1.
  - `d_sh <= {d, d_sh[WIDTH-1:1]}`.
  - `cnt` increments.
  - When `cnt == WIDTH-1` on a shift edge, go to DONE.
- **DONE:**
  - `diff = d_sh`, `borrow_out = br`, `out_valid=1`.
  - Both values are held stable until `out_valid && out_ready`, then go to IDLE.
- `in_valid` outside IDLE is ignored. Operands are not captured and the in-flight operation is unaffected.
- `a` and `b` are sampled only on the accept edge. Later changes have no effect.
- There is no overlap: the next accept happens earliest one cycle after the output handshake.
- Arithmetic is modulo 2^WIDTH. There is no sign interpretation; `borrow_out` is the only overflow indicator.

## Timing
- Reset values:
  - `in_ready=1`, `busy=0`, `out_valid=0`.
  - `diff=0`, `borrow_out=0`.
  - State IDLE; all internal registers 0.
- Accept edge T0, when `in_valid && in_ready` are sampled high:
  - `busy=1` and `in_ready=0` from cycle T0+1.
  - Shift edges are T0+1 … T0+WIDTH.
  - `out_valid=1` from cycle T0+WIDTH+1.
  - Accept-to-`out_valid` latency is exactly WIDTH+1 cycles.
- `busy` falls in the same cycle `out_valid` rises.
- Output handshake at edge T1:
  - `out_valid=0` and `in_ready=1` from cycle T1+1.
  - `diff` and `borrow_out` keep their last value until the next result. They are meaningful only when `out_valid=1`.
- Back-pressure: `out_ready` may stay low indefinitely. `out_valid`, `diff` and `borrow_out` must not change while waiting.
- `out_ready` high before `out_valid` has no effect.
- Reset mid-operation, `rst_n` low in SHIFT or DONE:
  - Immediate return to the reset values.
  - The partial result is discarded; no `out_valid` pulse is produced.
- A new operation after reset needs a fresh accept.

## Test plan
All cases with `WIDTH=8`.
- **Basic:** `a=5`, `b=3`, `out_ready=1`.
  - `out_valid` 9 cycles after accept, `diff=0x02`, `borrow_out=0`.
  - `in_ready` high the cycle after the handshake.
- **Underflow:**
  - `a=3`, `b=5` → `diff=0xFE`, `borrow_out=1`.
  - `a=0`, `b=1` → `diff=0xFF`, `borrow_out=1`.
- **Edge values:**
  - `a=0xFF`, `b=0xFF` → `diff=0x00`, `borrow_out=0`.
  - `a=0x80`, `b=0x01` → `diff=0x7F`, `borrow_out=0`.
  - `a=0x00`, `b=0x00` → `diff=0x00`, `borrow_out=0`.
- **Back-pressure and ignored input:**
  - Hold `out_ready=0` for 10 cycles after `out_valid` → `diff`/`borrow_out` stable throughout.
  - Pulse `in_valid` with new operands during SHIFT and DONE → ignored, and the result matches the first operands.
- **Reset mid-op:** accept `a=0xAA`, `b=0x55`, then drop `rst_n` for 1 cycle at the 4th shift cycle.
  - All outputs return to reset values at once, with no `out_valid`.
  - A subsequent `a=0x10`, `b=0x01` → `diff=0x0F`.
- **Random:** at least 1000 random operand pairs with random `out_ready` stalls.
  - `{borrow_out, diff}` must equal `{a < b, (a - b) & 0xFF}` for every pair.
  - Latency must be exactly 9 cycles from accept to `out_valid`.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b computed LSB first.
// Operands arrive on a ready/valid input, and the result leaves on a ready/valid output.
// The datapath is one full-subtractor cell plus a registered borrow, so an
// operation takes WIDTH shift cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             x_bit;
    logic             y_bit;
    logic             d_bit;
    logic             br_next;

    // Full-subtractor cell acting on the current LSBs and the running borrow
    always_comb begin
        x_bit   = a_sh_q[0];
        y_bit   = b_sh_q[0];
        d_bit   = x_bit ^ y_bit ^ br_q;
        br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    end

    // State register; reset drops any in-flight operation immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, count WIDTH shifts, wait for the sink
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SHIFT);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load on accept, shift one bit per SHIFT cycle, and latch
    // the finished result on the last shift so it stays put until the next result
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    br_d   = 1'b0;
                    cnt_d  = '0;
                end
            end
            SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d   = {d_bit, d_sh_q[WIDTH-1:1]};
                    borrow_d = br_next;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scenario tasks driving serial_subtractor (WIDTH=8), with
// expected {borrow, diff} values queued at accept time and popped at the output.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] sb_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Present one operand pair for a single accept edge and queue its expected result
    task automatic drive_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        logic [WIDTH-1:0] exp_d;
        logic             exp_b;
        @(negedge clk);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        exp_d    = op_a - op_b;
        exp_b    = (op_a < op_b);
        sb_q.push_back({exp_b, exp_d});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count negedges until out_valid shows up, bounded by TIMEOUT
    task automatic wait_out(output int lat, output bit timed_out);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < TIMEOUT);
        timed_out = !out_valid;
    endtask

    // Called at a negedge with out_valid high: stall, then take the result
    task automatic handshake(input int stall);
        out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        checks++;
        if ({in_ready, busy, out_valid, borrow_out, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_state: got rdy/busy/vld/br/diff=%b %b %b %b %h, want 1 0 0 0 00",
                     in_ready, busy, out_valid, borrow_out, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_release: got rdy/busy/vld=%b%b%b, want 100", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic;
        int             lat;
        bit             to;
        logic [WIDTH:0] exp;
        drive_op(8'd5, 8'd3);
        @(negedge clk);
        checks++;
        if ({busy, in_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL basic_busy: got busy/rdy=%b%b, want 10", busy, in_ready);
        end
        wait_out(lat, to);
        lat++;
        exp = sb_q.pop_front();
        checks++;
        if (to || lat != 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d (timeout=%0d), want 9", lat, to);
        end
        checks++;
        if ({borrow_out, diff} !== exp || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result: got br=%b diff=%h busy=%b, want br=%b diff=%h busy=0",
                     borrow_out, diff, busy, exp[WIDTH], exp[WIDTH-1:0]);
        end
        handshake(0);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL basic_after_hs: got vld/rdy=%b%b, want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors;
        logic [WIDTH-1:0] va[5] = '{8'h03, 8'h00, 8'hFF, 8'h80, 8'h00};
        logic [WIDTH-1:0] vb[5] = '{8'h05, 8'h01, 8'hFF, 8'h01, 8'h00};
        int               lat;
        bit               to;
        logic [WIDTH:0]   exp;
        for (int i = 0; i < 5; i++) begin
            drive_op(va[i], vb[i]);
            wait_out(lat, to);
            exp = sb_q.pop_front();
            checks++;
            if (to || lat != 9) begin
                errors++;
                $display("[TB] FAIL vec%0d_latency: got %0d (timeout=%0d), want 9", i, lat, to);
            end
            checks++;
            if ({borrow_out, diff} !== exp) begin
                errors++;
                $display("[TB] FAIL vec%0d_result: a=%h b=%h got br=%b diff=%h, want br=%b diff=%h",
                         i, va[i], vb[i], borrow_out, diff, exp[WIDTH], exp[WIDTH-1:0]);
            end
            handshake(0);
        end
    endtask

    task automatic test_back_pressure;
        int             lat;
        bit             to;
        logic [WIDTH:0] exp;
        drive_op(8'hC4, 8'h3A);
        wait_out(lat, to);
        exp = sb_q.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL bp_timeout: got no out_valid within %0d cycles, want out_valid", TIMEOUT);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {borrow_out, diff} !== exp) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got vld=%b br=%b diff=%h, want vld=1 br=%b diff=%h",
                         i, out_valid, borrow_out, diff, exp[WIDTH], exp[WIDTH-1:0]);
            end
            @(negedge clk);
        end
        handshake(0);
    endtask

    task automatic test_ignored_input;
        int             lat;
        bit             to;
        logic [WIDTH:0] exp;
        drive_op(8'h33, 8'h11);
        a        = 8'hFF;
        b        = 8'h00;
        in_valid = 1'b1;
        wait_out(lat, to);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL ign_done%0d: got rdy/vld=%b%b, want 01", i, in_ready, out_valid);
            end
            a = 8'h77;
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (to || lat != 9 || {borrow_out, diff} !== exp) begin
            errors++;
            $display("[TB] FAIL ign_result: got lat=%0d br=%b diff=%h, want lat=9 br=%b diff=%h",
                     lat, borrow_out, diff, exp[WIDTH], exp[WIDTH-1:0]);
        end
        handshake(0);
        @(negedge clk);
        checks++;
        if ({busy, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ign_no_accept: got busy/rdy=%b%b, want 01", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_op;
        int             lat;
        bit             to;
        bit             saw_valid;
        logic [WIDTH:0] exp;
        drive_op(8'hAA, 8'h55);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        checks++;
        if ({in_ready, busy, out_valid, borrow_out, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL midrst_state: got rdy/busy/vld/br/diff=%b %b %b %b %h, want 1 0 0 0 00",
                     in_ready, busy, out_valid, borrow_out, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("[TB] FAIL midrst_quiet: got out_valid/busy activity after reset, want none");
        end
        drive_op(8'h10, 8'h01);
        wait_out(lat, to);
        exp = sb_q.pop_front();
        checks++;
        if (to || lat != 9 || {borrow_out, diff} !== exp) begin
            errors++;
            $display("[TB] FAIL midrst_next: got lat=%0d br=%b diff=%h, want lat=9 br=%b diff=%h",
                     lat, borrow_out, diff, exp[WIDTH], exp[WIDTH-1:0]);
        end
        handshake(0);
    endtask

    task automatic test_random;
        int               lat;
        bit               to;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            drive_op(ra, rb);
            wait_out(lat, to);
            exp = sb_q.pop_front();
            checks++;
            if (to || lat != 9) begin
                errors++;
                $display("[TB] FAIL rand%0d_latency: got %0d (timeout=%0d), want 9", i, lat, to);
            end
            checks++;
            if ({borrow_out, diff} !== exp) begin
                errors++;
                $display("[TB] FAIL rand%0d_result: a=%h b=%h got br=%b diff=%h, want br=%b diff=%h",
                         i, ra, rb, borrow_out, diff, exp[WIDTH], exp[WIDTH-1:0]);
            end
            handshake($urandom_range(0, 3));
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_pressure();
        test_ignored_input();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
